// File: rtl/sram_arb_pkg.sv
// Shared constants and tag type for the SRAM word-port arbiter.
// Tag id width is fixed wide enough for any practical client count.
package sram_arb_pkg;
   localparam int unsigned RD_LAT   = 2;
   localparam int unsigned TAG_ID_W = 8;

   typedef struct packed {
      logic                v;
      logic [TAG_ID_W-1:0] id;
   } rd_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr_i, first requester wins.
// nxt_ptr_o points one past the winner, or holds ptr_i when nothing is granted.
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] nxt_ptr_o
);
   logic found;

   always_comb begin
      gnt_o     = '0;
      nxt_ptr_o = ptr_i;
      found     = 1'b0;
      for (int unsigned off = 0; off < N; off++) begin
         logic [PW-1:0] idx;
         idx = PW'((32'(ptr_i) + off) % N);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            nxt_ptr_o  = PW'((32'(idx) + 1) % N);
         end
      end
   end
endmodule

// File: rtl/sram_word_port_arb.sv
// Shares the SRAM read port round-robin among N_RD clients and the write port
// by fixed priority among N_WR clients; read data is routed back via a tag pipeline.
module sram_word_port_arb
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BYTE_W = DATA_W/8,
   parameter int unsigned N_RD   = 4,
   parameter int unsigned N_WR   = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_RD-1:0]                rd_req_valid,
   input  logic [N_RD*ADDR_W-1:0]         rd_req_addr,
   output logic [N_RD-1:0]                rd_req_ready,
   output logic [N_RD-1:0]                rd_rsp_valid,
   output logic [DATA_W-1:0]              rd_rsp_data,
   input  logic [N_WR-1:0]                wr_req_valid,
   input  logic [N_WR*ADDR_W-1:0]         wr_req_addr,
   input  logic [N_WR*DATA_W-1:0]         wr_req_data,
   input  logic [N_WR*BYTE_W-1:0]         wr_req_mask,
   output logic [N_WR-1:0]                wr_req_ready,
   output logic                           a_en,
   output logic                           a_re,
   output logic [ADDR_W-1:0]              a_addr,
   input  logic [DATA_W-1:0]              a_rdata,
   input  logic                           a_rvalid,
   output logic                           b_en,
   output logic                           b_we,
   output logic [ADDR_W-1:0]              b_addr,
   output logic [DATA_W-1:0]              b_wdata,
   output logic [BYTE_W-1:0]              b_wmask,
   output logic [$clog2(RD_LAT+1)-1:0]    rd_inflight,
   output logic                           err_rsp
);
   localparam int unsigned PW = $clog2(N_RD);
   localparam int unsigned CW = $clog2(RD_LAT+1);

   logic [PW-1:0]   rr_ptr_q, rr_ptr_d, rr_nxt;
   logic [N_RD-1:0] rd_gnt;
   logic [PW-1:0]   rd_win;
   logic            issue;
   rd_tag_t         tag_q [RD_LAT];
   rd_tag_t         tag_last;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic            err_q;
   logic            wr_found;

   // Masking requests during reset forces every grant and strobe low.
   rr_arbiter #(.N(N_RD)) u_rr (
      .req_i     (rd_req_valid & {N_RD{~rst}}),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (rd_gnt),
      .nxt_ptr_o (rr_nxt)
   );

   always_comb begin
      rd_win = '0;
      a_addr = '0;
      for (int unsigned i = 0; i < N_RD; i++) begin
         if (rd_gnt[i]) begin
            rd_win = PW'(i);
            a_addr = rd_req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign issue        = |rd_gnt;
   assign rd_req_ready = rd_gnt;
   assign a_en         = issue;
   assign a_re         = issue;
   assign rr_ptr_d     = issue ? rr_nxt : rr_ptr_q;
   assign tag_last     = tag_q[RD_LAT-1];
   assign inflight_d   = inflight_q + CW'(issue) - CW'(tag_last.v);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
         rr_ptr_q   <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         tag_q[0] <= '{v: issue, id: TAG_ID_W'(rd_win)};
         for (int unsigned i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= inflight_d;
         if (a_rvalid != tag_last.v) err_q <= 1'b1;
      end
   end

   // A response needs both the SRAM strobe and a live tag; either alone is dropped.
   always_comb begin
      rd_rsp_valid = '0;
      for (int unsigned i = 0; i < N_RD; i++) begin
         if (!rst && a_rvalid && tag_last.v && tag_last.id == TAG_ID_W'(i))
            rd_rsp_valid[i] = 1'b1;
      end
   end

   assign rd_rsp_data = a_rdata;
   assign rd_inflight = inflight_q;
   assign err_rsp     = err_q;

   always_comb begin
      wr_req_ready = '0;
      b_addr       = '0;
      b_wdata      = '0;
      b_wmask      = '0;
      wr_found     = 1'b0;
      for (int unsigned i = 0; i < N_WR; i++) begin
         if (!rst && !wr_found && wr_req_valid[i]) begin
            wr_found        = 1'b1;
            wr_req_ready[i] = 1'b1;
            b_addr          = wr_req_addr[i*ADDR_W +: ADDR_W];
            b_wdata         = wr_req_data[i*DATA_W +: DATA_W];
            b_wmask         = wr_req_mask[i*BYTE_W +: BYTE_W];
         end
      end
   end

   assign b_en = wr_found;
   assign b_we = wr_found;
endmodule

// File: tb/tb_sram_word_port_arb.sv
// Randomized scoreboard bench: a behavioural memory model predicts grants and
// read data; a separate monitor checks each response against the queue.
module tb_sram_word_port_arb;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 4;
   localparam int unsigned N_RD   = 4;
   localparam int unsigned N_WR   = 2;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic [N_RD-1:0]           rd_req_valid = '0;
   logic [N_RD*ADDR_W-1:0]    rd_req_addr  = '0;
   logic [N_RD-1:0]           rd_req_ready, rd_rsp_valid;
   logic [DATA_W-1:0]         rd_rsp_data;
   logic [N_WR-1:0]           wr_req_valid = '0;
   logic [N_WR*ADDR_W-1:0]    wr_req_addr  = '0;
   logic [N_WR*DATA_W-1:0]    wr_req_data  = '0;
   logic [N_WR*BYTE_W-1:0]    wr_req_mask  = '0;
   logic [N_WR-1:0]           wr_req_ready;
   logic                      a_en, a_re, a_rvalid, b_en, b_we;
   logic [ADDR_W-1:0]         a_addr, b_addr;
   logic [DATA_W-1:0]         a_rdata, b_wdata;
   logic [BYTE_W-1:0]         b_wmask;
   logic [1:0]                rd_inflight;
   logic                      err_rsp;
   logic                      force_rv = 1'b0;

   always #5 clk = ~clk;

   sram_word_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTE_W(BYTE_W),
                        .N_RD(N_RD), .N_WR(N_WR)) dut (
      .clk(clk), .rst(rst),
      .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
      .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
      .wr_req_mask(wr_req_mask), .wr_req_ready(wr_req_ready),
      .a_en(a_en), .a_re(a_re), .a_addr(a_addr), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask),
      .rd_inflight(rd_inflight), .err_rsp(err_rsp)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] init_val(input logic [ADDR_W-1:0] a);
      return 32'h1000_0000 + 32'(a) * 32'h0001_0101;
   endfunction

   // SRAM stub: 2-cycle latency, write-first on the array read cycle.
   logic [DATA_W-1:0] sram [1024];
   logic [1023:0]     sram_w = '0;
   logic              p1_v = 1'b0, p2_v = 1'b0;
   logic [ADDR_W-1:0] p1_a = '0;
   logic [DATA_W-1:0] p2_d = '0;

   function automatic logic [31:0] sram_rd(input logic [ADDR_W-1:0] a);
      return sram_w[a] ? sram[a] : init_val(a);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         p1_v <= 1'b0;
         p2_v <= 1'b0;
      end else begin
         p1_v <= a_en;
         p1_a <= a_addr;
         p2_v <= p1_v;
         p2_d <= (b_en && b_addr == p1_a) ? merge(sram_rd(p1_a), b_wdata, b_wmask)
                                          : sram_rd(p1_a);
         if (b_en) begin
            sram[b_addr]   <= merge(sram_rd(b_addr), b_wdata, b_wmask);
            sram_w[b_addr] <= 1'b1;
         end
      end
   end
   assign a_rvalid = p2_v | force_rv;
   assign a_rdata  = p2_d;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model state
   typedef struct {
      int unsigned       cl;
      logic [ADDR_W-1:0] addr;
      int unsigned       icyc;
      logic [DATA_W-1:0] data;
   } rd_t;

   rd_t               pend_q[$];
   rd_t               rsp_q[$];
   logic [DATA_W-1:0] ref_mem [1024];
   logic [1023:0]     ref_w = '0;
   int unsigned       cyc = 0;
   int unsigned       m_ptr = 0;
   int unsigned       iss1 = 0, iss2 = 0;
   logic              exp_err = 1'b0;
   logic [N_RD-1:0]   exp_rd_gnt = '0;
   logic [N_WR-1:0]   exp_wr_gnt = '0;

   function automatic logic [31:0] ref_rd(input logic [ADDR_W-1:0] a);
      return ref_w[a] ? ref_mem[a] : init_val(a);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [ADDR_W-1:0] wa;
      logic              got;
      int unsigned       win;
      rd_t               e;
      if (rst) begin
         m_ptr = 0; iss1 = 0; iss2 = 0; exp_err = 1'b0;
         exp_rd_gnt = '0; exp_wr_gnt = '0;
         pend_q.delete(); rsp_q.delete();
         chk("rst_rd_ready", 64'(rd_req_ready), 0);
         chk("rst_wr_ready", 64'(wr_req_ready), 0);
         chk("rst_strobes", 64'({a_en, a_re, b_en, b_we}), 0);
      end else begin
         exp_wr_gnt = '0;
         for (int i = 0; i < N_WR; i++)
            if (wr_req_valid[i] && exp_wr_gnt == '0) exp_wr_gnt[i] = 1'b1;
         chk("wr_ready", 64'(wr_req_ready), 64'(exp_wr_gnt));
         chk("b_strobe", 64'({b_en, b_we}), (exp_wr_gnt != '0) ? 64'd3 : 64'd0);
         for (int i = 0; i < N_WR; i++) begin
            if (exp_wr_gnt[i]) begin
               wa = wr_req_addr[i*ADDR_W +: ADDR_W];
               chk("b_addr", 64'(b_addr), 64'(wa));
               chk("b_wdata", 64'(b_wdata), 64'(wr_req_data[i*DATA_W +: DATA_W]));
               chk("b_wmask", 64'(b_wmask), 64'(wr_req_mask[i*BYTE_W +: BYTE_W]));
               ref_mem[wa] = merge(ref_rd(wa), wr_req_data[i*DATA_W +: DATA_W],
                                   wr_req_mask[i*BYTE_W +: BYTE_W]);
               ref_w[wa] = 1'b1;
            end
         end
         // A read observes every write up to and including the cycle after its issue.
         while (pend_q.size() != 0 && pend_q[0].icyc + 1 == cyc) begin
            e = pend_q.pop_front();
            e.data = ref_rd(e.addr);
            rsp_q.push_back(e);
         end
         exp_rd_gnt = '0; got = 1'b0; win = 0;
         for (int unsigned off = 0; off < N_RD; off++) begin
            if (!got && rd_req_valid[(m_ptr + off) % N_RD]) begin
               got = 1'b1;
               win = (m_ptr + off) % N_RD;
               exp_rd_gnt[win] = 1'b1;
            end
         end
         chk("rd_ready", 64'(rd_req_ready), 64'(exp_rd_gnt));
         chk("a_strobe", 64'({a_en, a_re}), got ? 64'd3 : 64'd0);
         if (got) begin
            chk("a_addr", 64'(a_addr), 64'(rd_req_addr[win*ADDR_W +: ADDR_W]));
            pend_q.push_back('{cl: win, addr: rd_req_addr[win*ADDR_W +: ADDR_W],
                               icyc: cyc, data: '0});
            m_ptr = (win + 1) % N_RD;
         end
         chk("inflight", 64'(rd_inflight), 64'(iss1 + iss2));
         chk("err_rsp", 64'(err_rsp), 64'(exp_err));
         if (force_rv && iss2 == 0) exp_err = 1'b1;
         iss2 = iss1;
         iss1 = got ? 1 : 0;
      end
   end

   // Response monitor
   always @(negedge clk) begin
      rd_t r;
      if (rst) begin
         chk("rsp_in_rst", 64'(rd_rsp_valid), 0);
      end else if (rd_rsp_valid != '0) begin
         if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", 64'(rd_rsp_valid), 0);
         end else begin
            r = rsp_q.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(r.icyc + 2));
            chk("rsp_client", 64'(rd_rsp_valid), 64'(1) << r.cl);
            chk("rsp_data", 64'(rd_rsp_data), 64'(r.data));
         end
      end else if (rsp_q.size() != 0 && rsp_q[0].icyc + 2 <= cyc) begin
         r = rsp_q.pop_front();
         chk("rsp_missing", 64'(rd_rsp_valid), 64'(1) << r.cl);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Clients keep valid/addr until the predicted transfer, then re-roll.
   task automatic rand_cycle(input int unsigned pct);
      tick();
      for (int i = 0; i < N_RD; i++) begin
         if (!rd_req_valid[i] || exp_rd_gnt[i]) begin
            rd_req_valid[i] = ($urandom_range(99) < pct);
            rd_req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(15));
         end
      end
      for (int i = 0; i < N_WR; i++) begin
         if (!wr_req_valid[i] || exp_wr_gnt[i]) begin
            wr_req_valid[i] = ($urandom_range(99) < pct);
            wr_req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(15));
            wr_req_data[i*DATA_W +: DATA_W] = $urandom;
            wr_req_mask[i*BYTE_W +: BYTE_W] = BYTE_W'($urandom_range(15));
         end
      end
   endtask

   task automatic set_wr(input int i, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic [3:0] m);
      wr_req_valid[i] = 1'b1;
      wr_req_addr[i*ADDR_W +: ADDR_W] = a;
      wr_req_data[i*DATA_W +: DATA_W] = d;
      wr_req_mask[i*BYTE_W +: BYTE_W] = m;
   endtask

   task automatic set_rd(input int i, input logic [ADDR_W-1:0] a);
      rd_req_valid[i] = 1'b1;
      rd_req_addr[i*ADDR_W +: ADDR_W] = a;
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;

      // Fairness from a fresh pointer
      for (int i = 0; i < N_RD; i++) set_rd(i, ADDR_W'(10'h020 + i));
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("fair_grant", 64'(rd_req_ready), 64'(1) << (k % 4));
         tick();
      end
      rd_req_valid = '0;
      repeat (3) tick();

      // Single read with back-to-back reissue
      set_wr(0, 10'h005, 32'hDEADBEEF, 4'hF);
      tick(); wr_req_valid = '0;
      tick();
      set_rd(2, 10'h005);
      @(negedge clk); chk("single_grant", 64'(rd_req_ready), 64'h4);
      tick();
      @(negedge clk); chk("single_inflight1", 64'(rd_inflight), 1);
      tick(); rd_req_valid = '0;
      @(negedge clk);
      chk("single_inflight2", 64'(rd_inflight), 2);
      chk("single_rsp_valid", 64'(rd_rsp_valid), 64'h4);
      chk("single_rsp_data", 64'(rd_rsp_data), 64'hDEADBEEF);
      repeat (3) tick();

      // Write priority, then read both words back
      set_wr(0, 10'h030, 32'hA0A0A0A0, 4'hF);
      set_wr(1, 10'h031, 32'hB1B1B1B1, 4'hF);
      @(negedge clk); chk("wprio_first", 64'(wr_req_ready), 64'h1);
      tick(); wr_req_valid[0] = 1'b0;
      @(negedge clk); chk("wprio_second", 64'(wr_req_ready), 64'h2);
      tick(); wr_req_valid[1] = 1'b0;
      set_rd(0, 10'h030);
      set_rd(1, 10'h031);
      repeat (5) rand_cycle(0);

      // Masked forwarding of a write in the cycle after the read issue
      set_wr(1, 10'h010, 32'h11223344, 4'hF);
      tick(); wr_req_valid = '0;
      tick();
      set_rd(3, 10'h010);
      tick(); rd_req_valid = '0;
      set_wr(0, 10'h010, 32'hAABBCCDD, 4'b0011);
      tick(); wr_req_valid = '0;
      @(negedge clk);
      chk("fwd_rsp_valid", 64'(rd_rsp_valid), 64'h8);
      chk("fwd_rsp_data", 64'(rd_rsp_data), 64'h1122CCDD);
      repeat (3) tick();

      // Reset while reads are in flight
      set_rd(0, 10'h040);
      tick(); rd_req_valid[0] = 1'b0;
      set_rd(1, 10'h041);
      rst = 1'b1;
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("rstflight_inflight", 64'(rd_inflight), 0);
      chk("rstflight_rsp", 64'(rd_rsp_valid), 0);
      chk("rstflight_err", 64'(err_rsp), 0);
      repeat (5) rand_cycle(0);

      // Randomized traffic
      repeat (400) rand_cycle(70);
      repeat (8) rand_cycle(0);

      // Spurious a_rvalid with an empty tag pipeline
      force_rv = 1'b1;
      tick(); force_rv = 1'b0;
      @(negedge clk);
      chk("fault_err_rise", 64'(err_rsp), 1);
      chk("fault_no_strobe", 64'(rd_rsp_valid), 0);
      repeat (3) tick();
      @(negedge clk); chk("fault_err_sticky", 64'(err_rsp), 1);

      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();
      @(negedge clk); chk("err_cleared", 64'(err_rsp), 0);
      chk("queue_drained", 64'(rsp_q.size() + pend_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
